// File: rtl/drum_pkg.sv
// Shared types and constants for the drum step sequencer.
package drum_pkg;

    typedef enum logic [1:0] {
        STOP,
        RUN,
        PAUSE
    } seq_state_t;

    localparam int MIN_PERIOD = 2;
    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_NUM_STEPS = 16;

endpackage

// File: rtl/drum_step_sequencer_step_timer.sv
// Step timer: latches the step length at each step start and counts ticks.
// Swing timing is present when DRUM_SEQ_SWING_EN is defined.
import drum_pkg::*;

module step_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                halt,
    input  logic [PERIOD_W-1:0] step_period,
`ifdef DRUM_SEQ_SWING_EN
    input  logic [PERIOD_W-1:0] swing,
    input  logic                step_odd,
`endif
    output logic                step_pulse,
    output logic                wrap
);

    localparam logic [PERIOD_W-1:0] MINP = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W-1:0] base;
    logic [PERIOD_W-1:0] eff;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] tick_cnt;
    logic                active;
`ifdef DRUM_SEQ_SWING_EN
    logic [PERIOD_W:0]   sum;
    logic [PERIOD_W:0]   floor_p;
`endif

    always_comb begin
        base = (step_period < MINP) ? MINP : step_period;
`ifdef DRUM_SEQ_SWING_EN
        sum = {1'b0, base} + {1'b0, swing};
        floor_p = {1'b0, swing} + (PERIOD_W+1)'(MIN_PERIOD);
        // even steps stretch (saturating), odd steps shrink to no less than MINP
        if (!step_odd) begin
            eff = sum[PERIOD_W] ? '1 : sum[PERIOD_W-1:0];
        end else if ({1'b0, base} < floor_p) begin
            eff = MINP;
        end else begin
            eff = base - swing;
        end
`else
        eff = base;
`endif
    end

    assign wrap = active && (tick_cnt == period_q - 1'b1);

    always_ff @(posedge clk) begin
        if (rst || halt) begin
            tick_cnt   <= '0;
            step_pulse <= 1'b0;
            active     <= 1'b0;
            if (rst) begin
                period_q <= MINP;
            end
        end else if (load) begin
            tick_cnt   <= '0;
            step_pulse <= 1'b1;
            active     <= 1'b1;
            period_q   <= eff;
        end else begin
            step_pulse <= 1'b0;
            if (active) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/drum_step_sequencer.sv
// Pattern-driven drum step sequencer producing retriggered voice gates.
// Optional swing timing: define DRUM_SEQ_SWING_EN.
import drum_pkg::*;

module drum_step_sequencer #(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NUM_STEPS  = DEF_NUM_STEPS,
    parameter int PERIOD_W   = 24,
    localparam int VW = $clog2(NUM_VOICES),
    localparam int SW = $clog2(NUM_STEPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [PERIOD_W-1:0]   step_period,
`ifdef DRUM_SEQ_SWING_EN
    input  logic [PERIOD_W-1:0]   swing,
`endif
    input  logic                  wr_en,
    input  logic [VW-1:0]         wr_voice,
    input  logic [SW-1:0]         wr_step,
    input  logic                  wr_data,
    output logic [NUM_VOICES-1:0] voice_en,
    output logic [SW-1:0]         step_idx,
    output logic                  step_pulse,
    output logic                  running
);

    seq_state_t state;

    logic [NUM_VOICES-1:0] pattern [NUM_STEPS];
    logic [NUM_VOICES-1:0] hit;
    logic                  halt;
    logic                  go;
    logic                  wrap;
    logic                  load;
    logic [SW-1:0]         load_idx;

    // stop outranks pause, which outranks start
    always_comb begin
        halt = 1'b0;
        go   = 1'b0;
        unique case (state)
            STOP: go = start & ~stop & ~pause;
            RUN: halt = stop | pause;
            PAUSE: begin
                halt = stop;
                go   = start & ~stop & ~pause;
            end
            default: ;
        endcase
    end

    assign load     = go | (wrap & ~halt);
    assign load_idx = go ? step_idx : step_idx + 1'b1;
    assign running  = (state == RUN);

    step_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .halt       (halt),
        .step_period(step_period),
`ifdef DRUM_SEQ_SWING_EN
        .swing      (swing),
        .step_odd   (load_idx[0]),
`endif
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOP;
            step_idx <= '0;
            hit      <= '0;
            voice_en <= '0;
            for (int s = 0; s < NUM_STEPS; s++) begin
                pattern[s] <= '0;
            end
        end else begin
            if (wr_en) begin
                pattern[wr_step][wr_voice] <= wr_data;
            end
            // hit latch reads the pre-write pattern; gates drop for the gap cycle
            if (load) begin
                state    <= RUN;
                step_idx <= load_idx;
                hit      <= pattern[load_idx];
                voice_en <= '0;
            end else if (halt) begin
                voice_en <= '0;
                if (stop) begin
                    state    <= STOP;
                    step_idx <= '0;
                end else begin
                    state <= PAUSE;
                end
            end else if (state == RUN) begin
                voice_en <= hit;
            end
        end
    end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Self-checking bench for drum_step_sequencer with a rule-level reference model.
module tb_drum_step_sequencer;

    localparam int NV = 4;
    localparam int NS = 16;
    localparam int PW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stop, pause, wr_en, wr_data;
    logic [PW-1:0] step_period;
    logic [1:0]    wr_voice;
    logic [3:0]    wr_step;
    logic [NV-1:0] voice_en;
    logic [3:0]    step_idx;
    logic          step_pulse, running;
`ifdef DRUM_SEQ_SWING_EN
    logic [PW-1:0] swing;
`endif

    drum_step_sequencer #(
        .NUM_VOICES(NV),
        .NUM_STEPS (NS),
        .PERIOD_W  (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .step_period(step_period),
`ifdef DRUM_SEQ_SWING_EN
        .swing      (swing),
`endif
        .wr_en      (wr_en),
        .wr_voice   (wr_voice),
        .wr_step    (wr_step),
        .wr_data    (wr_data),
        .voice_en   (voice_en),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .running    (running)
    );

    int checks = 0;
    int passes = 0;

    wire [9:0] dut_obs = {voice_en, step_idx, step_pulse, running};

    // Reference model: state 0=stopped 1=playing 2=paused
    int        m_state, m_idx, m_pos, m_len;
    bit [NV-1:0] m_hit;
    bit [NV-1:0] m_pat [NS];

    function automatic int step_len(int i);
        longint p;
        p = (step_period < 2) ? 2 : longint'(step_period);
`ifdef DRUM_SEQ_SWING_EN
        if (i % 2 == 0) begin
            p = p + longint'(swing);
            if (p > (longint'(1) << PW) - 1) p = (longint'(1) << PW) - 1;
        end else begin
            p = p - longint'(swing);
            if (p < 2) p = 2;
        end
`endif
        return int'(p);
    endfunction

    task automatic enter(int i);
        m_state = 1;
        m_idx   = i;
        m_pos   = 0;
        m_len   = step_len(i);
        m_hit   = m_pat[i];
    endtask

    task automatic model_edge();
        if (rst) begin
            m_state = 0; m_idx = 0; m_pos = 0; m_hit = '0;
            for (int s = 0; s < NS; s++) m_pat[s] = '0;
        end else begin
            case (m_state)
                0: if (start && !stop && !pause) enter(0);
                1: begin
                    if (stop) begin m_state = 0; m_idx = 0; end
                    else if (pause) m_state = 2;
                    else if (m_pos == m_len - 1) enter((m_idx + 1) % NS);
                    else m_pos++;
                end
                default: begin
                    if (stop) begin m_state = 0; m_idx = 0; end
                    else if (start && !pause) enter(m_idx);
                end
            endcase
            if (wr_en) m_pat[wr_step][wr_voice] = wr_data;
        end
    endtask

    function automatic logic [9:0] exp_vec();
        logic [NV-1:0] ve;
        logic [3:0] ix;
        ve = (m_state == 1 && m_pos != 0) ? m_hit : '0;
        ix = 4'(m_idx);
        return {ve, ix, m_state == 1 && m_pos == 0, m_state == 1};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse_cmd(input int which);
        if (which == 0) start = 1'b1;
        if (which == 1) stop = 1'b1;
        if (which == 2) pause = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0; pause = 1'b0;
    endtask

    task automatic write(input int v, input int s, input bit d);
        wr_en = 1'b1; wr_voice = 2'(v); wr_step = 4'(s); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_obs !== 10'h0) $display("FAIL reset_hold got %h need %h", dut_obs, 10'h0);
            else passes++;
        end
        rst = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (dut_obs !== exp_vec()) $display("FAIL reset_release got %h need %h", dut_obs, exp_vec());
        else passes++;
    endtask

    task automatic test_basic();
        int pulses = 0;
        int v0 = 0;
        int last_idx = 0;
        write(0, 0, 1'b1);
        write(0, 2, 1'b1);
        step_period = 5;
        pulse_cmd(0);
        for (int i = 0; i < 80; i++) begin
            checks++;
            if (dut_obs !== exp_vec()) $display("FAIL basic_model got %h need %h", dut_obs, exp_vec());
            else passes++;
            pulses += int'(step_pulse);
            v0 += int'(voice_en[0]);
            last_idx = int'(step_idx);
            tick();
        end
        checks++;
        if (pulses != 16) $display("FAIL basic_pulses got %0d need 16", pulses);
        else passes++;
        checks++;
        if (v0 != 8) $display("FAIL basic_v0_cycles got %0d need 8", v0);
        else passes++;
        checks++;
        if (last_idx != 15 || step_idx !== 4'd0 || step_pulse !== 1'b1)
            $display("FAIL basic_wrap got last=%0d idx=%0d pulse=%b need 15 0 1", last_idx, step_idx, step_pulse);
        else passes++;
        pulse_cmd(1);
    endtask

    task automatic test_gap();
        for (int s = 0; s < NS; s++) write(1, s, 1'b1);
        step_period = 4;
        pulse_cmd(0);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (voice_en[1] !== (i % 4 != 0) || dut_obs !== exp_vec())
                $display("FAIL gap_pattern got %h need %h (v1 want %0d)", dut_obs, exp_vec(), i % 4 != 0);
            else passes++;
            tick();
        end
        pulse_cmd(1);
    endtask

    task automatic test_pause_stop();
        int n = 0;
        int seen = 0;
        pulse_cmd(0);
        while (step_idx !== 4'd5 && n < 200) begin tick(); n++; end
        checks++;
        if (step_idx !== 4'd5) $display("FAIL pause_wait got idx %0d need 5", step_idx);
        else passes++;
        tick();
        pulse_cmd(2);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (dut_obs !== exp_vec()) $display("FAIL pause_model got %h need %h", dut_obs, exp_vec());
            else passes++;
            seen += int'(step_pulse) + int'(|voice_en) + int'(running);
            tick();
        end
        checks++;
        if (seen != 0) $display("FAIL pause_idle got %0d need 0", seen);
        else passes++;
        pulse_cmd(0);
        checks++;
        if (step_idx !== 4'd5 || step_pulse !== 1'b1 || running !== 1'b1)
            $display("FAIL resume got idx=%0d pulse=%b need 5 1", step_idx, step_pulse);
        else passes++;
        repeat (6) tick();
        pulse_cmd(1);
        checks++;
        if (step_idx !== 4'd0 || voice_en !== 4'd0 || running !== 1'b0)
            $display("FAIL stop got idx=%0d ven=%h run=%b need 0 0 0", step_idx, voice_en, running);
        else passes++;
    endtask

    task automatic test_boundary();
        int pulses;
        int n;
        for (int p = 0; p < 2; p++) begin
            pulses = 0;
            step_period = PW'(p);
            pulse_cmd(0);
            for (int i = 0; i < 10; i++) begin
                pulses += int'(step_pulse);
                tick();
            end
            checks++;
            if (pulses != 5) $display("FAIL clamp_p%0d got %0d pulses need 5", p, pulses);
            else passes++;
            pulse_cmd(1);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        checks++;
        if (running !== 1'b0 || dut_obs !== exp_vec()) $display("FAIL stop_start got run=%b need 0", running);
        else passes++;
        step_period = 3;
        pulse_cmd(0);
        n = 0;
        while (step_idx !== 4'd3 && n < 100) begin tick(); n++; end
        tick();
        write(2, 3, 1'b1);
        checks++;
        if (voice_en[2] !== 1'b0 || dut_obs !== exp_vec())
            $display("FAIL cur_write_same got %b need 0", voice_en[2]);
        else passes++;
        tick();
        n = 0;
        while (step_idx !== 4'd3 && n < 100) begin tick(); n++; end
        tick();
        checks++;
        if (voice_en[2] !== 1'b1 || dut_obs !== exp_vec())
            $display("FAIL cur_write_next got %b need 1", voice_en[2]);
        else passes++;
        pulse_cmd(1);
    endtask

`ifdef DRUM_SEQ_SWING_EN
    task automatic test_swing();
        int q[$];
        step_period = 10; swing = 3;
        pulse_cmd(0);
        for (int i = 0; i < 40; i++) begin if (step_pulse) q.push_back(i); tick(); end
        checks++;
        if (q.size() < 3 || q[1] - q[0] != 13 || q[2] - q[1] != 7)
            $display("FAIL swing3 got %0d %0d need 13 7", q[1] - q[0], q[2] - q[1]);
        else passes++;
        pulse_cmd(1);
        q.delete();
        swing = 9;
        pulse_cmd(0);
        for (int i = 0; i < 40; i++) begin if (step_pulse) q.push_back(i); tick(); end
        checks++;
        if (q.size() < 3 || q[1] - q[0] != 19 || q[2] - q[1] != 2)
            $display("FAIL swing9 got %0d %0d need 19 2", q[1] - q[0], q[2] - q[1]);
        else passes++;
        pulse_cmd(1);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 14) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            pause    = ($urandom_range(0, 29) == 0);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_voice = 2'($urandom_range(0, 3));
            wr_step  = 4'($urandom_range(0, 15));
            wr_data  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) step_period = PW'($urandom_range(0, 6));
`ifdef DRUM_SEQ_SWING_EN
            if ($urandom_range(0, 19) == 0) swing = PW'($urandom_range(0, 4));
`endif
            tick();
            checks++;
            if (dut_obs !== exp_vec()) $display("FAIL random_%0d got %h need %h", i, dut_obs, exp_vec());
            else passes++;
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        wr_en = 1'b0; wr_voice = '0; wr_step = '0; wr_data = 1'b0;
        step_period = 5;
`ifdef DRUM_SEQ_SWING_EN
        swing = '0;
`endif
        m_state = 0; m_idx = 0; m_pos = 0; m_len = 2; m_hit = '0;
        for (int s = 0; s < NS; s++) m_pat[s] = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_gap();
        test_pause_stop();
        test_boundary();
`ifdef DRUM_SEQ_SWING_EN
        test_swing();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
